// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: fixed-latency multiply/divide sequencer owning the HI/LO pair.
// Define MDU_FLUSH_EN to add the flush port and in-flight/issue cancellation.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  E_op,
  input  logic [5:0]  E_fuc,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_md_use,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_md_out,
  output logic        D_stall_md
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = 32'd0 - v;
  endfunction

  state_t      state_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic [31:0] hi_r, lo_r, hi_nxt_s, lo_nxt_s;
  logic [31:0] sh_hi_r, sh_lo_r, sh_hi_nxt_s, sh_lo_nxt_s;
  logic        dz_r, dz_nxt_s;
  logic        flush_s;

  logic        is_mult_s, is_multu_s, is_div_s, is_divu_s;
  logic        is_mthi_s, is_mtlo_s, is_mfhi_s, is_mflo_s;
  logic        is_mul_grp_s, is_div_grp_s;

  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic        rs_neg_s, rt_neg_s, dz_s;
  logic [31:0] dvd_s, dvs_s, quo_s, rem_s, div_q_s, div_r_s;

`ifdef MDU_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Decode the E-stage instruction; only R-type opcodes carry md functions.
  always_comb begin
    is_mult_s  = 1'b0;
    is_multu_s = 1'b0;
    is_div_s   = 1'b0;
    is_divu_s  = 1'b0;
    is_mthi_s  = 1'b0;
    is_mtlo_s  = 1'b0;
    is_mfhi_s  = 1'b0;
    is_mflo_s  = 1'b0;
    if (E_op == 6'b000000) begin
      case (E_fuc)
        FN_MULT:  is_mult_s  = 1'b1;
        FN_MULTU: is_multu_s = 1'b1;
        FN_DIV:   is_div_s   = 1'b1;
        FN_DIVU:  is_divu_s  = 1'b1;
        FN_MTHI:  is_mthi_s  = 1'b1;
        FN_MTLO:  is_mtlo_s  = 1'b1;
        FN_MFHI:  is_mfhi_s  = 1'b1;
        FN_MFLO:  is_mflo_s  = 1'b1;
        default:  is_mult_s  = 1'b0;
      endcase
    end else begin
      is_mult_s = 1'b0;
    end
  end

  assign is_mul_grp_s = is_mult_s | is_multu_s;
  assign is_div_grp_s = is_div_s | is_divu_s;

  // One 64x64 multiplier: low 64 bits are correct for both signed and unsigned extension.
  always_comb begin
    if (is_mult_s) begin
      mul_a_s = {{32{E_rs_data[31]}}, E_rs_data};
      mul_b_s = {{32{E_rt_data[31]}}, E_rt_data};
    end else begin
      mul_a_s = {32'd0, E_rs_data};
      mul_b_s = {32'd0, E_rt_data};
    end
    prod_s = mul_a_s * mul_b_s;
  end

  // One unsigned divider on magnitudes; signs restored after. A zero divisor is
  // replaced by 1 only to keep the datapath defined, its result is never committed.
  always_comb begin
    rs_neg_s = is_div_s & E_rs_data[31];
    rt_neg_s = is_div_s & E_rt_data[31];
    dz_s     = (E_rt_data == 32'd0);
    dvd_s    = rs_neg_s ? neg32(E_rs_data) : E_rs_data;
    if (dz_s) begin
      dvs_s = 32'd1;
    end else if (rt_neg_s) begin
      dvs_s = neg32(E_rt_data);
    end else begin
      dvs_s = E_rt_data;
    end
    quo_s   = dvd_s / dvs_s;
    rem_s   = dvd_s % dvs_s;
    div_q_s = (rs_neg_s ^ rt_neg_s) ? neg32(quo_s) : quo_s;
    div_r_s = rs_neg_s ? neg32(rem_s) : rem_s;
  end

  assign state_s = (cnt_r != 4'd0) ? BUSY : IDLE;

  // State register: counter, busy flag, shadow result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      sh_hi_r <= 32'd0;
      sh_lo_r <= 32'd0;
      dz_r    <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      sh_hi_r <= sh_hi_nxt_s;
      sh_lo_r <= sh_lo_nxt_s;
      dz_r    <= dz_nxt_s;
    end
  end

  // Next-state: issue/mt* only when idle; md instructions arriving while busy are ignored.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    sh_hi_nxt_s = sh_hi_r;
    sh_lo_nxt_s = sh_lo_r;
    dz_nxt_s    = dz_r;
    case (state_s)
      IDLE: begin
        if (flush_s) begin
          cnt_nxt_s = 4'd0;
        end else if (is_mul_grp_s) begin
          sh_hi_nxt_s = prod_s[63:32];
          sh_lo_nxt_s = prod_s[31:0];
          dz_nxt_s    = 1'b0;
          cnt_nxt_s   = MULT_CNT;
        end else if (is_div_grp_s) begin
          sh_hi_nxt_s = div_r_s;
          sh_lo_nxt_s = div_q_s;
          dz_nxt_s    = dz_s;
          cnt_nxt_s   = DIV_CNT;
        end else if (is_mthi_s) begin
          hi_nxt_s = E_rs_data;
        end else if (is_mtlo_s) begin
          lo_nxt_s = E_rs_data;
        end else begin
          cnt_nxt_s = 4'd0;
        end
      end
      BUSY: begin
        if (flush_s) begin
          cnt_nxt_s   = 4'd0;
          sh_hi_nxt_s = 32'd0;
          sh_lo_nxt_s = 32'd0;
          dz_nxt_s    = 1'b0;
        end else if (cnt_r == 4'd1) begin
          cnt_nxt_s = 4'd0;
          if (!dz_r) begin
            hi_nxt_s = sh_hi_r;
            lo_nxt_s = sh_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        cnt_nxt_s = 4'd0;
      end
    endcase
    busy_nxt_s = (cnt_nxt_s != 4'd0);
  end

  // Outputs: start/E_md_out/D_stall_md are same-cycle views of the E/D stages.
  always_comb begin
    start = is_mul_grp_s | is_div_grp_s;
    busy  = busy_r;
    HI    = hi_r;
    LO    = lo_r;
    if (is_mfhi_s) begin
      E_md_out = hi_r;
    end else if (is_mflo_s) begin
      E_md_out = lo_r;
    end else begin
      E_md_out = 32'd0;
    end
    D_stall_md = D_md_use & (start | busy_r);
  end

endmodule
